// File: rtl/demux_stream_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_router_pkg
// Purpose  : Shared helpers for the registered stream demultiplexer: the
//            layout of channel slices on the flat DemuxOut bus.
// Revision : 1.0 - initial release
// ============================================================================
package demux_stream_router_pkg;

  // Channel c owns DemuxOut[c*width +: width].
  function automatic int sliceLsb(input int chan, input int width);
    return chan * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_stream_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_slot
// Purpose  : One output channel of the stream router. It is a one-entry
//            register (full flag plus data word) with load/drain control.
//            A load wins over a drain in the same cycle, which gives
//            pass-through at one word per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module demux_stream_slot
  import demux_stream_router_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int HOLD_LAST  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_loadData,
  input  logic                  i_outReady,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_data;

  // Load takes priority; otherwise a handshake on the output empties the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_loadData;
    end else if (r_full && i_outReady) begin
      r_full <= 1'b0;
      if (HOLD_LAST == 0) begin
        r_data <= '0;
      end
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/demux_stream_router.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_router
// Purpose  : Registered valid/ready demultiplexer. It routes DemuxIn to one
//            of NUM_CHANNELS one-entry output slots selected by Sel. Each
//            channel stalls independently of the others.
// Revision : 1.0 - initial release
// ============================================================================
module demux_stream_router
  import demux_stream_router_pkg::*;
#(
  parameter int DATA_WIDTH   = 1,
  parameter int NUM_CHANNELS = 32,
  parameter int SEL_WIDTH    = 5,
  parameter int HOLD_LAST    = 0
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               Enable,
  input  logic [SEL_WIDTH-1:0]               Sel,
  input  logic [DATA_WIDTH-1:0]              DemuxIn,
  input  logic                               InValid,
  output logic                               InReady,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] DemuxOut,
  output logic [NUM_CHANNELS-1:0]            OutValid,
  input  logic [NUM_CHANNELS-1:0]            OutReady,
  output logic                               SelError,
  output logic                               Busy
);

  // One extra bit so that NUM_CHANNELS == 2**SEL_WIDTH is representable.
  localparam logic [SEL_WIDTH:0] c_NUM_CHANNELS = NUM_CHANNELS[SEL_WIDTH:0];

  logic                    w_inRange;
  logic [NUM_CHANNELS-1:0] w_selHot;
  logic [NUM_CHANNELS-1:0] w_full;
  logic [NUM_CHANNELS-1:0] w_slotOpen;
  logic                    w_accept;
  logic                    r_selError;

  assign w_inRange = ({1'b0, Sel} < c_NUM_CHANNELS);

  // A slot can take a word when it is empty or is emptying this cycle.
  assign w_slotOpen = ~w_full | OutReady;

  // The one-hot decode only covers valid channels, so an out-of-range Sel
  // never indexes past the slot array.
  assign InReady  = Enable & w_inRange & (|(w_selHot & w_slotOpen));
  assign w_accept = InValid & InReady;

  genvar g;
  generate
    for (g = 0; g < NUM_CHANNELS; g++) begin : g_slot
      localparam logic [SEL_WIDTH:0] c_IDX = g[SEL_WIDTH:0];
      localparam int                 c_LSB = sliceLsb(g, DATA_WIDTH);

      logic [DATA_WIDTH-1:0] w_slotData;

      assign w_selHot[g] = ({1'b0, Sel} == c_IDX);

      demux_stream_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .HOLD_LAST  (HOLD_LAST)
      ) u_slot (
        .clk        (Clock),
        .rst        (Reset),
        .i_load     (w_accept & w_selHot[g]),
        .i_loadData (DemuxIn),
        .i_outReady (OutReady[g]),
        .o_full     (w_full[g]),
        .o_data     (w_slotData)
      );

      assign DemuxOut[c_LSB +: DATA_WIDTH] = w_slotData;
    end
  endgenerate

  // Flag one cycle for each cycle in which a valid, enabled word has a bad select.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_selError <= 1'b0;
    end else begin
      r_selError <= InValid & Enable & ~w_inRange;
    end
  end

  assign SelError = r_selError;
  assign OutValid = w_full;
  assign Busy     = |w_full;

endmodule
`default_nettype wire

// File: doc/demux_stream_router.md
Name: demux_stream_router

Overview:
- Parametrised, registered successor to the fixed 32-way combinational demultiplexer in the CPU plexers library.
- Routes a DATA_WIDTH-bit word to one of NUM_CHANNELS outputs selected by Sel, using a valid/ready handshake on the input and on every output.
- Each channel has a one-entry output register, so a stalled consumer on one channel does not block traffic to the others.
- Used between the CPU write path and peripheral sinks (video, sound, score registers).

Parameters:
- DATA_WIDTH, 1, width of the routed word.
- NUM_CHANNELS, 32, number of output channels; range 2..64, need not be a power of 2.
- SEL_WIDTH, 5, width of Sel; must satisfy 2**SEL_WIDTH >= NUM_CHANNELS.
- HOLD_LAST, 0, 1 = a channel keeps its last data after drain; 0 = channel data clears to 0 on drain.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  global enable; 0 blocks all new accepts.
- Sel  input  SEL_WIDTH  destination channel index.
- DemuxIn  input  DATA_WIDTH  input word.
- InValid  input  1  input word valid.
- InReady  output  1  router can accept this cycle (combinational).
- DemuxOut  output  NUM_CHANNELS*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- OutValid  output  NUM_CHANNELS  per-channel valid, registered.
- OutReady  input  NUM_CHANNELS  per-channel consumer ready.
- SelError  output  1  registered one-cycle pulse on an out-of-range select.
- Busy  output  1  OR of all OutValid bits.

Behaviour:
- One clock. Reset is asynchronous and active-high: Clock and Reset as named above.
- Reset values: full[] = 0, data[] = 0, SelError = 0. Hence OutValid = 0, DemuxOut = 0, Busy = 0. Reset asserted mid-transfer discards all buffered words; no partial state survives.
- Per-channel state: full[c] (drives OutValid[c]) and data[c].
- in_range = (Sel < NUM_CHANNELS).
- InReady = Enable & in_range & (!full[Sel] | OutReady[Sel]). It is 0 whenever Enable = 0 or Sel is out of range.
- accept = InValid & InReady.
- drain[c] = full[c] & OutReady[c].
- Each clock, per channel c:
  - accept & Sel == c: data[c] <= DemuxIn, full[c] <= 1. This holds even if drain[c] is 1 in the same cycle (pass-through at full throughput).
  - otherwise, if drain[c]: full[c] <= 0, and data[c] <= 0 when HOLD_LAST = 0.
  - otherwise: channel holds its state.
- Latency: a word accepted at edge N appears on OutValid/DemuxOut after edge N. The sustained rate is one word per cycle per channel while the consumer keeps OutReady high.
- Drains on different channels are independent and concurrent. Only one channel can load per cycle.
- While OutValid[c] = 1 and OutReady[c] = 0, DemuxOut channel c holds stable.
- SelError <= InValid & Enable & !in_range, asserted for one cycle per offending cycle. The word is not accepted and InReady stays 0. The producer must change Sel or drop InValid.
- Enable = 0 does not stop drains; buffered words still leave.
- InValid low: no state change other than drains.
- Sel and DemuxIn are ignored when InValid = 0. No X may propagate from them into state.
- Data width arithmetic: none. Indexing uses Sel truncated to SEL_WIDTH; the range check is done before indexing.

Decomposition:
- No shared package needed. A local function or constant computes channel slice offsets.
- One natural sub-module: demux_stream_slot, the single-channel register pair (full, data) with load/drain logic and the HOLD_LAST parameter. It is instantiated NUM_CHANNELS times via generate. The top level holds only the select decode, InReady mux, SelError register and Busy OR.

Test Plan:
- Reset: assert Reset asynchronously mid-cycle with channels 3 and 7 full -> OutValid = 0, DemuxOut = 0, SelError = 0 immediately, with no clock edge required.
- Basic route, defaults (DATA_WIDTH = 1): Sel = 5, DemuxIn = 1, InValid = 1, OutReady = all-1 -> OutValid = 32'h0000_0020 and DemuxOut[5] = 1 one cycle later; the next cycle returns to 0 (HOLD_LAST = 0).
- Backpressure, DATA_WIDTH = 8: send 8'hA5 to channel 2 with OutReady[2] = 0 -> channel 2 holds 8'hA5. A second word to channel 2 sees InReady = 0. A word to channel 9 (8'h3C) is accepted in the same cycle. Raising OutReady[2] drains 8'hA5, then accepts the pending word.
- Full throughput: stream 0x01..0x10 to channel 0 with OutReady[0] = 1 -> InReady stays 1, 16 words arrive on consecutive cycles in order, Busy stays 1.
- Range check, NUM_CHANNELS = 20, SEL_WIDTH = 5: Sel = 25, InValid = 1, Enable = 1 -> InReady = 0, SelError pulses for 1 cycle, no OutValid bit set. Repeating with Enable = 0 -> SelError stays 0.
- HOLD_LAST = 1: route 8'h7E to channel 4 and drain -> OutValid[4] = 0 and DemuxOut channel 4 stays 8'h7E until the next load or Reset.
